// File: rtl/fetch_unit_pkg.sv
// Shared widths, instruction encodings and FSM state encoding for the fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_W = 15;
  localparam int ADDR_W  = 8;
  localparam int COUNT_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COUNT_W-1:0] count_t;

  localparam instr_t HALT_WORD_DEFAULT = 15'h7FFF;
  localparam instr_t NOP_WORD_DEFAULT  = 15'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Fetch counter sticks at all-ones instead of wrapping.
  function automatic count_t sat_inc(input count_t c);
    return (&c) ? c : count_t'(c + 1'b1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/jump controls, instruction-memory port and IF/ID outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic   stall;
  logic   jump_en;
  addr_t  jump_addr;
  addr_t  im_address;
  instr_t im_data;
  instr_t if_instr;
  addr_t  if_pc;
  logic   if_valid;
  logic   halted;
  count_t fetch_count;

  modport master (
    input  stall, jump_en, jump_addr, im_data,
    output im_address, if_instr, if_pc, if_valid, halted, fetch_count
  );

  modport slave (
    output stall, jump_en, jump_addr, im_data,
    input  im_address, if_instr, if_pc, if_valid, halted, fetch_count
  );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// 8-bit program counter: synchronous reset, load, increment (wraps 255 -> 0), else hold.
module pc_register
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  addr_t load_addr,
  input  logic  inc,
  output addr_t pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (load)
      pc <= load_addr;
    else if (inc)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, halt FSM and saturating fetch counter.
//   state  | meaning
//   RUN    | fetching; jump > stall > normal fetch
//   HALTED | HALT_WORD latched; PC frozen, bubbles until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter instr_t HALT_WORD = HALT_WORD_DEFAULT,
  parameter instr_t NOP_WORD  = NOP_WORD_DEFAULT
)
(
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  addr_t        pc;
  logic         pc_load, pc_inc;
  instr_t       instr_q, instr_d;
  addr_t        ifpc_q, ifpc_d;
  logic         valid_q, valid_d;
  count_t       count_q, count_d;

  pc_register u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .load_addr (bus.jump_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      RUN: begin
        if (bus.jump_en) begin
          // Flush: the word currently on im_data belongs to the wrong path.
          pc_load = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.im_data;
          ifpc_d  = pc;
          valid_d = 1'b1;
          count_d = sat_inc(count_q);
          if (bus.im_data == HALT_WORD)
            state_d = HALTED;
          else
            pc_inc = 1'b1;
        end
      end
      HALTED: begin
        if (!bus.stall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.im_address  = pc;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = ifpc_q;
  assign bus.if_valid    = valid_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus random stall/jump/reset traffic.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] mem [256];
  always_comb bus.im_data = mem[bus.im_address];

  int errors = 0;
  int checks = 0;

  // Reference state, updated from the behavioural rules once per clock.
  logic [7:0]  m_pc;
  logic [14:0] m_instr;
  logic [7:0]  m_ifpc;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit j, input logic [7:0] ja);
    logic [14:0] w;
    if (r) begin
      m_pc = 0; m_instr = 15'h0000; m_ifpc = 0; m_valid = 0; m_halted = 0; m_count = 0;
    end else if (m_halted) begin
      if (!s) begin
        m_instr = 15'h0000;
        m_valid = 0;
      end
    end else if (j) begin
      m_pc = ja;
      m_instr = 15'h0000;
      m_valid = 0;
    end else if (!s) begin
      w = mem[m_pc];
      m_instr = w;
      m_ifpc = m_pc;
      m_valid = 1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (w == 15'h7FFF) m_halted = 1;
      else m_pc = (m_pc + 8'd1) % 256;
    end
  endtask

  task automatic compare_all();
    chk("pc",     32'(bus.im_address),  32'(m_pc));
    chk("instr",  32'(bus.if_instr),    32'(m_instr));
    chk("if_pc",  32'(bus.if_pc),       32'(m_ifpc));
    chk("valid",  32'(bus.if_valid),    32'(m_valid));
    chk("halted", 32'(bus.halted),      32'(m_halted));
    chk("count",  32'(bus.fetch_count), 32'(m_count));
  endtask

  task automatic cycle(input bit r, input bit s, input bit j, input logic [7:0] ja, input bit do_chk);
    reset = r;
    bus.stall = s;
    bus.jump_en = j;
    bus.jump_addr = ja;
    model_step(r, s, j, ja);
    @(posedge clk);
    #1;
    if (do_chk) compare_all();
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 15'(i * 7 + 16);
    mem[0] = 15'h0001; mem[1] = 15'h0002; mem[2] = 15'h0003; mem[3] = 15'h0004;
    mem[8'h40] = 15'h0123;
    mem[8'hFF] = 15'h0ABC;

    // Reset state and free run over 0..3
    cycle(1, 0, 0, 8'h00, 1);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 8'h00, 1);
      chk("run_instr", 32'(bus.if_instr), 32'(i + 1));
      chk("run_ifpc",  32'(bus.if_pc),    32'(i));
    end
    chk("run_count", 32'(bus.fetch_count), 32'd4);

    // Stall three cycles holding 0002
    cycle(1, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 8'h00, 1);
      chk("stall_instr", 32'(bus.if_instr), 32'h0002);
      chk("stall_pc",    32'(bus.im_address), 32'd2);
      chk("stall_count", 32'(bus.fetch_count), 32'd2);
    end
    cycle(0, 0, 0, 8'h00, 1);
    chk("post_stall", 32'(bus.if_instr), 32'h0003);

    // Jump wins over stall, one bubble
    cycle(0, 1, 1, 8'h40, 1);
    chk("jmp_valid", 32'(bus.if_valid), 32'd0);
    chk("jmp_instr", 32'(bus.if_instr), 32'd0);
    cycle(0, 0, 0, 8'h00, 1);
    chk("jmp_ifpc",  32'(bus.if_pc), 32'h40);
    chk("jmp_word",  32'(bus.if_instr), 32'h0123);

    // PC wrap 255 -> 0
    cycle(0, 0, 1, 8'hFF, 1);
    cycle(0, 0, 0, 8'h00, 1);
    chk("wrap_ff", 32'(bus.if_pc), 32'hFF);
    cycle(0, 0, 0, 8'h00, 1);
    chk("wrap_00", 32'(bus.if_pc), 32'h00);
    chk("wrap_halt", 32'(bus.halted), 32'd0);

    // Halt at address 5
    mem[4] = 15'h0005;
    mem[5] = 15'h7FFF;
    cycle(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);
    chk("halt_instr", 32'(bus.if_instr), 32'h7FFF);
    chk("halt_valid", 32'(bus.if_valid), 32'd1);
    chk("halt_flag",  32'(bus.halted), 32'd1);
    chk("halt_pc",    32'(bus.im_address), 32'd5);
    cycle(0, 1, 0, 8'h00, 1);
    chk("halt_stall", 32'(bus.if_instr), 32'h7FFF);
    cycle(0, 0, 1, 8'h40, 1);
    chk("halt_jpc",   32'(bus.im_address), 32'd5);
    chk("halt_bub",   32'(bus.if_valid), 32'd0);
    cycle(1, 0, 0, 8'h00, 1);
    chk("halt_rst",   32'(bus.halted), 32'd0);
    chk("halt_rpc",   32'(bus.im_address), 32'd0);

    // Reset beats stall and jump
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(1, 1, 1, 8'h40, 1);
    chk("rst_pc",    32'(bus.im_address), 32'd0);
    chk("rst_count", 32'(bus.fetch_count), 32'd0);

    // Random traffic
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 15'h7FFF : 15'($urandom_range(0, 32766));
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)), 1);
    end

    // Counter saturation
    for (int i = 0; i < 256; i++) mem[i] = 15'(i + 1);
    cycle(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 65533; i++) cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 1);
    chk("sat_fffe", 32'(bus.fetch_count), 32'hFFFE);
    cycle(0, 0, 0, 8'h00, 1);
    chk("sat_ffff", 32'(bus.fetch_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1);
    chk("sat_hold", 32'(bus.fetch_count), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
